// File: rtl/ps2_ascii_decoder.sv
// PS/2 Set-2 scan-code to ASCII decoder with prefix FSM, modifier tracking and FWFT output FIFO.
// Optional macro PS2_CTRL_CODES_EN: Ctrl+letter emits the ASCII control code.
module ps2_ascii_decoder #(
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] UNKNOWN_CHAR = 8'h2A,
  parameter bit         DROP_UNKNOWN = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    scan_code,
  input  logic                          scan_code_ready,
  output logic [7:0]                    ascii_code,
  output logic                          ascii_valid,
  input  logic                          ascii_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          shift_o,
  output logic                          caps_lock_o,
  output logic                          ctrl_o,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

  state_t        state_reg, state_next;
  logic          lshift_reg, lshift_next;
  logic          rshift_reg, rshift_next;
  logic          lctrl_reg, lctrl_next;
  logic          rctrl_reg, rctrl_next;
  logic          caps_reg, caps_next;
  logic          caps_held_reg, caps_held_next;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          overflow_reg;
  logic [7:0]    mem [FIFO_DEPTH];

  logic       is_f0, is_e0, is_ctrl_byte;
  logic       key_event, key_break, key_ext;
  logic [7:0] letter_lc;
  logic       glyph_hit;
  logic [7:0] glyph_base, glyph_shift;
  logic       fixed_hit;
  logic [7:0] fixed_char;
  logic       is_modifier;
  logic       norm_valid, ext_valid;
  logic [7:0] norm_char, ext_char;
  logic       push_req, push_ok, pop, full;
  logic [7:0] push_char;

  assign is_f0 = (scan_code == 8'hF0);
  assign is_e0 = (scan_code == 8'hE0);
  assign is_ctrl_byte = (scan_code == 8'h00) || (scan_code == 8'hAA) || (scan_code == 8'hEE) ||
                        (scan_code == 8'hFA) || (scan_code == 8'hFE) || (scan_code == 8'hFF);
  assign is_modifier = (scan_code == 8'h12) || (scan_code == 8'h59) ||
                       (scan_code == 8'h14) || (scan_code == 8'h58);

  assign shift_o     = lshift_reg | rshift_reg;
  assign ctrl_o      = lctrl_reg | rctrl_reg;
  assign caps_lock_o = caps_reg;
  assign overflow    = overflow_reg;
  assign fifo_count  = count_reg;
  assign ascii_valid = (count_reg != '0);
  assign ascii_code  = ascii_valid ? mem[rd_ptr_reg] : 8'h00;

  // Letter keys, lowercase form; 0 means not a letter.
  always_comb begin
    letter_lc = 8'h00;
    case (scan_code)
      8'h1C: letter_lc = "a";  8'h32: letter_lc = "b";  8'h21: letter_lc = "c";
      8'h23: letter_lc = "d";  8'h24: letter_lc = "e";  8'h2B: letter_lc = "f";
      8'h34: letter_lc = "g";  8'h33: letter_lc = "h";  8'h43: letter_lc = "i";
      8'h3B: letter_lc = "j";  8'h42: letter_lc = "k";  8'h4B: letter_lc = "l";
      8'h3A: letter_lc = "m";  8'h31: letter_lc = "n";  8'h44: letter_lc = "o";
      8'h4D: letter_lc = "p";  8'h15: letter_lc = "q";  8'h2D: letter_lc = "r";
      8'h1B: letter_lc = "s";  8'h2C: letter_lc = "t";  8'h3C: letter_lc = "u";
      8'h2A: letter_lc = "v";  8'h1D: letter_lc = "w";  8'h22: letter_lc = "x";
      8'h35: letter_lc = "y";  8'h1A: letter_lc = "z";
      default: letter_lc = 8'h00;
    endcase
  end

  // Digits and punctuation, US layout: unshifted and shifted glyph.
  always_comb begin
    glyph_hit   = 1'b1;
    glyph_base  = 8'h00;
    glyph_shift = 8'h00;
    case (scan_code)
      8'h45: begin glyph_base = "0";  glyph_shift = ")";  end
      8'h16: begin glyph_base = "1";  glyph_shift = "!";  end
      8'h1E: begin glyph_base = "2";  glyph_shift = "@";  end
      8'h26: begin glyph_base = "3";  glyph_shift = "#";  end
      8'h25: begin glyph_base = "4";  glyph_shift = "$";  end
      8'h2E: begin glyph_base = "5";  glyph_shift = "%";  end
      8'h36: begin glyph_base = "6";  glyph_shift = "^";  end
      8'h3D: begin glyph_base = "7";  glyph_shift = "&";  end
      8'h3E: begin glyph_base = "8";  glyph_shift = "*";  end
      8'h46: begin glyph_base = "9";  glyph_shift = "(";  end
      8'h0E: begin glyph_base = 8'h60; glyph_shift = 8'h7E; end
      8'h4E: begin glyph_base = "-";  glyph_shift = "_";  end
      8'h55: begin glyph_base = "=";  glyph_shift = "+";  end
      8'h5D: begin glyph_base = 8'h5C; glyph_shift = 8'h7C; end
      8'h54: begin glyph_base = "[";  glyph_shift = "{";  end
      8'h5B: begin glyph_base = "]";  glyph_shift = "}";  end
      8'h4C: begin glyph_base = ";";  glyph_shift = ":";  end
      8'h52: begin glyph_base = 8'h27; glyph_shift = 8'h22; end
      8'h41: begin glyph_base = ",";  glyph_shift = "<";  end
      8'h49: begin glyph_base = ".";  glyph_shift = ">";  end
      8'h4A: begin glyph_base = "/";  glyph_shift = "?";  end
      default: glyph_hit = 1'b0;
    endcase
  end

  always_comb begin
    fixed_hit  = 1'b1;
    fixed_char = 8'h00;
    case (scan_code)
      8'h29:   fixed_char = 8'h20;
      8'h5A:   fixed_char = 8'h0D;
      8'h66:   fixed_char = 8'h08;
      8'h0D:   fixed_char = 8'h09;
      default: fixed_hit = 1'b0;
    endcase
  end

  // Character for a non-extended make under the current modifier state.
  always_comb begin
    norm_valid = 1'b0;
    norm_char  = 8'h00;
    if (letter_lc != 8'h00) begin
      norm_valid = 1'b1;
`ifdef PS2_CTRL_CODES_EN
      if (ctrl_o)
        norm_char = letter_lc & 8'h1F;
      else
        norm_char = (shift_o ^ caps_reg) ? (letter_lc ^ 8'h20) : letter_lc;
`else
      norm_char = (shift_o ^ caps_reg) ? (letter_lc ^ 8'h20) : letter_lc;
`endif
    end else if (glyph_hit) begin
      norm_valid = 1'b1;
      norm_char  = shift_o ? glyph_shift : glyph_base;
    end else if (fixed_hit) begin
      norm_valid = 1'b1;
      norm_char  = fixed_char;
    end else if (!is_modifier && !DROP_UNKNOWN) begin
      norm_valid = 1'b1;
      norm_char  = UNKNOWN_CHAR;
    end
  end

  always_comb begin
    ext_valid = 1'b1;
    ext_char  = 8'h00;
    case (scan_code)
      8'h5A:   ext_char = 8'h0D;
      8'h4A:   ext_char = 8'h2F;
      default: ext_valid = 1'b0;
    endcase
  end

  // Prefix FSM and modifier bookkeeping for one received byte.
  always_comb begin
    state_next     = state_reg;
    lshift_next    = lshift_reg;
    rshift_next    = rshift_reg;
    lctrl_next     = lctrl_reg;
    rctrl_next     = rctrl_reg;
    caps_next      = caps_reg;
    caps_held_next = caps_held_reg;
    key_event      = 1'b0;
    key_break      = 1'b0;
    key_ext        = 1'b0;
    push_req       = 1'b0;
    push_char      = 8'h00;
    if (scan_code_ready) begin
      if (is_ctrl_byte) begin
        state_next = S_IDLE;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (is_f0)      state_next = S_BRK;
            else if (is_e0) state_next = S_EXT;
            else            key_event  = 1'b1;
          end
          S_EXT: begin
            if (is_f0)      state_next = S_EXT_BRK;
            else if (is_e0) state_next = S_EXT;
            else begin key_event = 1'b1; key_ext = 1'b1; end
          end
          S_BRK: begin
            if (is_f0)      state_next = S_BRK;
            else if (is_e0) state_next = S_EXT_BRK;
            else begin key_event = 1'b1; key_break = 1'b1; end
          end
          default: begin
            if (!is_f0 && !is_e0) begin
              key_event = 1'b1;
              key_break = 1'b1;
              key_ext   = 1'b1;
            end
          end
        endcase
      end
    end

    if (key_event) begin
      state_next = S_IDLE;
      if (!key_ext) begin
        case (scan_code)
          8'h12: lshift_next = !key_break;
          8'h59: rshift_next = !key_break;
          8'h14: lctrl_next  = !key_break;
          8'h58: begin
            // Typematic repeats of caps lock must not re-toggle.
            if (key_break) begin
              caps_held_next = 1'b0;
            end else if (!caps_held_reg) begin
              caps_next      = !caps_reg;
              caps_held_next = 1'b1;
            end
          end
          default: ;
        endcase
      end else if (scan_code == 8'h14) begin
        rctrl_next = !key_break;
      end
      if (!key_break) begin
        push_req  = key_ext ? ext_valid : norm_valid;
        push_char = key_ext ? ext_char : norm_char;
      end
    end
  end

  assign full    = (count_reg == DEPTH_CNT);
  assign pop     = ascii_valid & ascii_ready;
  assign push_ok = push_req & (!full | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      lshift_reg    <= 1'b0;
      rshift_reg    <= 1'b0;
      lctrl_reg     <= 1'b0;
      rctrl_reg     <= 1'b0;
      caps_reg      <= 1'b0;
      caps_held_reg <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lshift_reg    <= lshift_next;
      rshift_reg    <= rshift_next;
      lctrl_reg     <= lctrl_next;
      rctrl_reg     <= rctrl_next;
      caps_reg      <= caps_next;
      caps_held_reg <= caps_held_next;
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg     <= count_reg + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
      overflow_reg  <= push_req & full & !pop;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_char;
  end

endmodule
